// File: rtl/onehot_arb_pkg.sv
// Shared sizing and types for the one-hot round-robin arbiter feeding the 8:3 encoder.
package onehot_arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = $clog2(ARB_N);

  typedef logic [ARB_N-1:0]     req_vec_t;
  typedef logic [ARB_IDX_W-1:0] arb_idx_t;

endpackage

// File: rtl/rr_mask_pick.sv
// Combinational round-robin pick: first set bit of src at or after ptr_s, wrapping mod N.
module rr_mask_pick
  import onehot_arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     src,
  input  logic [IDX_W-1:0] ptr_s,
  output logic             found,
  output logic [IDX_W-1:0] pick,
  output logic [N-1:0]     pick_onehot
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] keep;
  logic [2*N-1:0] masked;

  // Doubling src and masking off bits below ptr_s turns the wrapped search
  // into a plain lowest-set-bit search; the upper copy covers the wrap.
  always_comb begin
    dbl    = {src, src};
    keep   = ~(({{(2*N-1){1'b0}}, 1'b1} << ptr_s) - 1'b1);
    masked = dbl & keep;
    found  = |src;
    pick   = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) begin
        pick = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
      end
    end
    pick_onehot = found ? (N'(1) << pick) : '0;
  end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and valid/ready hold.
// Define STICKY_REQ_EN to capture request pulses until granted and accepted.
module onehot_rr_arbiter
  import onehot_arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  output logic [N-1:0]     grant_onehot,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
);

  logic [N-1:0]     pending;
  logic [N-1:0]     pending_next;
  logic [N-1:0]     src;
  logic [N-1:0]     pick_onehot;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_s;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic             accept;
  logic             load;

  assign accept   = grant_valid & grant_ready;
  assign load     = ~grant_valid | accept;
  assign idx_next = (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + 1'b1;
  assign ptr_s    = accept ? idx_next : ptr;

`ifdef STICKY_REQ_EN
  // The accepted bit retires from pending, but a same-cycle request re-pends it.
  logic [N-1:0] retire;
  assign retire       = accept ? grant_onehot : '0;
  assign src          = pending & ~retire;
  assign pending_next = src | req_in;
`else
  assign src          = pending;
  assign pending_next = req_in;
`endif

  rr_mask_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .src         (src),
    .ptr_s       (ptr_s),
    .found       (found),
    .pick        (pick),
    .pick_onehot (pick_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ptr     <= '0;
    end else begin
      pending <= pending_next;
      if (accept) ptr <= idx_next;
    end
  end

  // A stalled grant holds untouched; only load may change what the encoder sees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_onehot <= '0;
      grant_idx    <= '0;
      grant_valid  <= 1'b0;
    end else if (load) begin
      grant_onehot <= found ? pick_onehot : '0;
      grant_idx    <= found ? pick : '0;
      grant_valid  <= found;
    end
  end

  assign busy = (|pending) | grant_valid;

endmodule
